// File: rtl/ex_cond_stage.sv
// Decode-to-execute stage register plus the architectural NZCV flags register.
// Optional COND_UNDEF_TRAP_EN makes condition 4'b1111 an undefined-instruction trap.
module ex_cond_stage #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000,
    parameter logic [3:0] BUBBLE_COND = 4'b1110
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic [3:0] CondD,
    input  logic [1:0] FlagsWriteD,
    input  logic       PCSrcD,
    input  logic       RegWriteD,
    input  logic       MemWriteD,
    input  logic       MemtoRegD,
    input  logic       BranchD,
    output logic [3:0] CondE,
    output logic [3:0] FlagsE,
    output logic [1:0] FlagsWriteE,
    input  logic       CondExE,
    input  logic [3:0] FlagsNextE,
    output logic       ValidE,
    output logic       PCSrcGE,
    output logic       RegWriteGE,
    output logic       MemWriteGE,
    output logic       BranchTakenE,
    output logic       MemtoRegE,
    output logic       UndefE
);

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] fw;
        logic       pcsrc;
        logic       regw;
        logic       memw;
        logic       mtr;
        logic       br;
        logic       valid;
    } ex_slot_t;

    localparam ex_slot_t BUBBLE_SLOT = {BUBBLE_COND, 2'b00, 6'b000000};

    ex_slot_t   slot_q, slot_d;
    logic [3:0] flags_q, flags_d;
    logic       undef;
    logic       pass;

`ifdef COND_UNDEF_TRAP_EN
    assign undef = slot_q.valid && (slot_q.cond == 4'b1111);
`else
    assign undef = 1'b0;
`endif

    // Bubbles and trapped instructions never fire side effects.
    assign pass = CondExE & slot_q.valid & ~undef;

    always_comb begin
        slot_d = slot_q;
        if (FlushE) begin
            slot_d = BUBBLE_SLOT;
        end else if (!StallE) begin
            slot_d.cond  = CondD;
            slot_d.fw    = FlagsWriteD;
            slot_d.pcsrc = PCSrcD;
            slot_d.regw  = RegWriteD;
            slot_d.memw  = MemWriteD;
            slot_d.mtr   = MemtoRegD;
            slot_d.br    = BranchD;
            slot_d.valid = 1'b1;
        end
    end

    // Commit only when the instruction leaves E; the checker already masked per field.
    always_comb begin
        flags_d = flags_q;
        if (slot_q.valid && !StallE && !undef)
            flags_d = FlagsNextE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= BUBBLE_SLOT;
            flags_q <= FLAGS_RESET;
        end else begin
            slot_q  <= slot_d;
            flags_q <= flags_d;
        end
    end

    assign CondE        = slot_q.cond;
    assign FlagsE       = flags_q;
    assign FlagsWriteE  = slot_q.fw;
    assign ValidE       = slot_q.valid;
    assign PCSrcGE      = slot_q.pcsrc & pass;
    assign RegWriteGE   = slot_q.regw & pass;
    assign MemWriteGE   = slot_q.memw & pass;
    assign BranchTakenE = slot_q.br & pass;
    assign MemtoRegE    = slot_q.mtr;
    assign UndefE       = undef;

endmodule
